data_mem: RTL and testbench

- Single-port-write, single-port-read 32-bit data memory for the processor datapath; serves load/store traffic from the memory stage.
- Separate read and write address buses, so a read of one word and a write of another can occur in the same cycle.
- Writes are synchronous on the clock.
- Reads are combinational (asynchronous) so load data is available in the same cycle the address is presented.

---
 rtl/data_mem_if.sv | 28 ++
 rtl/data_mem.sv | 68 ++++++
 tb/tb_data_mem.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - read/write bus bundle for data_mem
// master drives the addresses and store data; slave returns the combinational load data.
interface data_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
);
   logic [ADDR_WIDTH-1:0] readAddress;
   logic [DATA_WIDTH-1:0] readData;
   logic [ADDR_WIDTH-1:0] writeAddress;
   logic [DATA_WIDTH-1:0] writeData;
   logic                  readWrite;

   modport master (
      output readAddress,
      output writeAddress,
      output writeData,
      output readWrite,
      input  readData
   );

   modport slave (
      input  readAddress,
      input  writeAddress,
      input  writeData,
      input  readWrite,
      output readData
   );
endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - 1W/1R word-addressed data memory, synchronous write, combinational read
// Optional store-to-load forwarding when DMEM_WRITE_BYPASS_EN is defined.
module data_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int DEPTH      = 512
) (
   input  logic       clk,
   input  logic       reset,
   data_mem_if.slave  bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  bypass_hit;
   logic [DATA_WIDTH-1:0] stored_word;
   logic [DATA_WIDTH-1:0] read_word;

   assign wr_idx = bus.writeAddress[IDX_W-1:0];
   assign rd_idx = bus.readAddress[IDX_W-1:0];

   // Only a partially populated address space needs a range decode.
   generate
      if (DEPTH < (1 << ADDR_WIDTH)) begin : g_partial
         assign wr_in_range = 32'(bus.writeAddress) < 32'(DEPTH);
         assign rd_in_range = 32'(bus.readAddress) < 32'(DEPTH);
      end else begin : g_full
         assign wr_in_range = 1'b1;
         assign rd_in_range = 1'b1;
      end
   endgenerate

   always_comb begin
      mem_d = mem_q;
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
      end else if (bus.readWrite && wr_in_range) begin
         mem_d[wr_idx] = bus.writeData;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
`ifdef DMEM_WRITE_BYPASS_EN
      bypass_hit = !reset && bus.readWrite && (bus.readAddress == bus.writeAddress);
`else
      bypass_hit = 1'b0;
`endif
   end

   always_comb begin
      stored_word = rd_in_range ? mem_q[rd_idx] : '0;
      read_word   = bypass_hit ? bus.writeData : stored_word;
   end

   assign bus.readData = read_word;
endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - scoreboard bench for data_mem
// Define DMEM_WRITE_BYPASS_EN to expect forwarding in the read-during-write scenario.
module tb_data_mem;
   localparam int DW    = 32;
   localparam int AW    = 9;
   localparam int DEPTH = 512;

   logic clk = 1'b0;
   logic reset;

   data_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   data_mem #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] model [DEPTH];
   int            pass_cnt  = 0;
   int            total_cnt = 0;
   logic [DW-1:0] got;
   logic [DW-1:0] exp_v;

   task automatic test_reset();
      logic [AW-1:0] addrs [4];
      addrs = '{9'd0, 9'd10, 9'd11, 9'd511};
      @(negedge clk);
      reset            = 1'b1;
      bus.readWrite    = 1'b0;
      bus.readAddress  = '0;
      bus.writeAddress = '0;
      bus.writeData    = '0;
      @(posedge clk);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      @(negedge clk);
      reset = 1'b0;
      foreach (addrs[k]) begin
         bus.readAddress = addrs[k];
         exp_q.push_back(32'd0);
         #2;
         got   = bus.readData;
         exp_v = exp_q.pop_front();
         total_cnt++;
         if (got !== exp_v) $display("FAIL reset_read addr=%0d got %h expected %h", addrs[k], got, exp_v);
         else pass_cnt++;
      end
   endtask

   task automatic test_write_read();
      logic [AW-1:0] wa [2];
      logic [DW-1:0] wd [2];
      wa = '{9'd10, 9'd11};
      wd = '{32'd12345, 32'd6789};
      bus.readAddress = '0;
      foreach (wa[k]) begin
         @(negedge clk);
         bus.readWrite    = 1'b1;
         bus.writeAddress = wa[k];
         bus.writeData    = wd[k];
         exp_q.push_back(model[0]);
         @(posedge clk);
         model[wa[k]] = wd[k];
         #2;
         got   = bus.readData;
         exp_v = exp_q.pop_front();
         total_cnt++;
         if (got !== exp_v) $display("FAIL write_addr0_stable step=%0d got %h expected %h", k, got, exp_v);
         else pass_cnt++;
      end
      @(negedge clk);
      bus.readWrite = 1'b0;
      foreach (wa[k]) begin
         bus.readAddress = wa[k];
         exp_q.push_back(wd[k]);
         #1;
         got   = bus.readData;
         exp_v = exp_q.pop_front();
         total_cnt++;
         if (got !== exp_v) $display("FAIL comb_read addr=%0d got %h expected %h", wa[k], got, exp_v);
         else pass_cnt++;
      end
   endtask

   task automatic test_no_write();
      bus.readAddress = 9'd10;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         bus.readWrite    = 1'b0;
         bus.writeAddress = 9'd10;
         bus.writeData    = 32'd999;
         exp_q.push_back(32'd12345);
         @(posedge clk);
         #2;
         got   = bus.readData;
         exp_v = exp_q.pop_front();
         total_cnt++;
         if (got !== exp_v) $display("FAIL readwrite0_hold edge=%0d got %h expected %h", n, got, exp_v);
         else pass_cnt++;
      end
   endtask

   task automatic test_read_during_write();
      @(negedge clk);
      bus.readWrite    = 1'b1;
      bus.writeAddress = 9'd20;
      bus.writeData    = 32'd5;
      bus.readAddress  = 9'd0;
      @(posedge clk);
      model[20] = 32'd5;
      @(negedge clk);
      bus.readAddress  = 9'd20;
      bus.writeAddress = 9'd20;
      bus.writeData    = 32'd7;
`ifdef DMEM_WRITE_BYPASS_EN
      exp_q.push_back(32'd7);
`else
      exp_q.push_back(32'd5);
`endif
      exp_q.push_back(32'd7);
      #2;
      got   = bus.readData;
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (got !== exp_v) $display("FAIL rdw_before_edge got %h expected %h", got, exp_v);
      else pass_cnt++;
      @(posedge clk);
      model[20] = 32'd7;
      #2;
      got   = bus.readData;
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (got !== exp_v) $display("FAIL rdw_after_edge got %h expected %h", got, exp_v);
      else pass_cnt++;
      @(negedge clk);
      bus.readWrite = 1'b0;
   endtask

   task automatic test_reset_priority();
      logic [AW-1:0] addrs [3];
      addrs = '{9'd3, 9'd10, 9'd11};
      @(negedge clk);
      reset            = 1'b1;
      bus.readWrite    = 1'b1;
      bus.writeAddress = 9'd3;
      bus.writeData    = 32'hDEADBEEF;
      @(posedge clk);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      @(negedge clk);
      reset         = 1'b0;
      bus.readWrite = 1'b0;
      foreach (addrs[k]) begin
         bus.readAddress = addrs[k];
         exp_q.push_back(32'd0);
         #1;
         got   = bus.readData;
         exp_v = exp_q.pop_front();
         total_cnt++;
         if (got !== exp_v) $display("FAIL reset_over_write addr=%0d got %h expected %h", addrs[k], got, exp_v);
         else pass_cnt++;
      end
   endtask

   task automatic test_top_address();
      @(negedge clk);
      bus.readWrite    = 1'b1;
      bus.writeAddress = 9'd511;
      bus.writeData    = 32'hFFFFFFFF;
      @(posedge clk);
      model[511] = 32'hFFFFFFFF;
      @(negedge clk);
      bus.readWrite   = 1'b0;
      bus.readAddress = 9'd511;
      exp_q.push_back(32'hFFFFFFFF);
      #1;
      got   = bus.readData;
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (got !== exp_v) $display("FAIL top_addr_read got %h expected %h", got, exp_v);
      else pass_cnt++;
      bus.readAddress = 9'd0;
      exp_q.push_back(32'd0);
      #1;
      got   = bus.readData;
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (got !== exp_v) $display("FAIL addr0_untouched got %h expected %h", got, exp_v);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         a                = AW'(100 + 7 * n);
         d                = $urandom;
         bus.readWrite    = 1'b1;
         bus.writeAddress = a;
         bus.writeData    = d;
         @(posedge clk);
         model[a] = d;
      end
      @(negedge clk);
      bus.readWrite = 1'b0;
      for (int n = 0; n < 8; n++) begin
         a               = AW'(100 + 7 * n);
         bus.readAddress = a;
         exp_q.push_back(model[a]);
         #1;
         got   = bus.readData;
         exp_v = exp_q.pop_front();
         total_cnt++;
         if (got !== exp_v) $display("FAIL back_to_back addr=%0d got %h expected %h", a, got, exp_v);
         else pass_cnt++;
      end
   endtask

   initial begin
      reset            = 1'b1;
      bus.readWrite    = 1'b0;
      bus.readAddress  = '0;
      bus.writeAddress = '0;
      bus.writeData    = '0;
      test_reset();
      test_write_read();
      test_no_write();
      test_read_during_write();
      test_back_to_back();
      test_reset_priority();
      test_top_address();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
